mem_stage_ctrl: RTL

//  MEM-stage controller; consumes the EX/MEM pipeline register outputs.

---
 rtl/mem_stage_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: resolves branch select, runs loads/stores over a req/ack
// data-memory bus with timeout, stalls the pipe while busy and registers MEM/WB.
module mem_stage_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        regWriteM,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic        BranchM,
  input  logic        ZeroM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] PCBranchM,
  output logic        PCSrcM,
  output logic [31:0] PCBranchOut,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        regWriteW,
  output logic        MemToRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic        mem_to_reg_w_q, mem_to_reg_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic [31:0] alu_out_w_q, alu_out_w_d;
  logic [4:0]  write_reg_w_q, write_reg_w_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;

  logic memop, is_load, misaligned, wait_expired, wb_reg_write;

  // A combined load+store is executed as a store and never writes back.
  assign memop        = MemWriteM | MemToRegM;
  assign is_load      = MemToRegM & ~MemWriteM;
  assign wb_reg_write = regWriteM & ~(MemWriteM & MemToRegM);
  assign misaligned   = (ALUOutM[1:0] != 2'b00);
  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (memop && !misaligned) state_d = BUSY;
      BUSY: if (dmem_ack || wait_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall          = 1'b0;
    wait_cnt_d     = '0;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    reg_write_w_d  = 1'b0;
    mem_to_reg_w_d = 1'b0;
    read_data_w_d  = read_data_w_q;
    alu_out_w_d    = alu_out_w_q;
    write_reg_w_d  = write_reg_w_q;
    align_err_d    = 1'b0;
    bus_err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop && misaligned) begin
          align_err_d    = 1'b1;
          mem_to_reg_w_d = is_load;
          alu_out_w_d    = ALUOutM;
          write_reg_w_d  = WriteRegM;
        end else if (memop) begin
          stall        = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = MemWriteM;
          dmem_addr_d  = ALUOutM;
          dmem_wdata_d = WriteDataM;
        end else begin
          reg_write_w_d  = regWriteM;
          mem_to_reg_w_d = MemToRegM;
          alu_out_w_d    = ALUOutM;
          write_reg_w_d  = WriteRegM;
        end
      end
      BUSY: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (dmem_ack) begin
          dmem_req_d     = 1'b0;
          reg_write_w_d  = wb_reg_write;
          mem_to_reg_w_d = is_load;
          alu_out_w_d    = ALUOutM;
          write_reg_w_d  = WriteRegM;
          if (is_load) read_data_w_d = dmem_rdata;
        end else if (wait_expired) begin
          dmem_req_d     = 1'b0;
          bus_err_d      = 1'b1;
          mem_to_reg_w_d = is_load;
          alu_out_w_d    = ALUOutM;
          write_reg_w_d  = WriteRegM;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q     <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      read_data_w_q  <= '0;
      alu_out_w_q    <= '0;
      write_reg_w_q  <= '0;
      align_err_q    <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_out_w_q    <= alu_out_w_d;
      write_reg_w_q  <= write_reg_w_d;
      align_err_q    <= align_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign PCSrcM      = BranchM & ZeroM;
  assign PCBranchOut = PCBranchM;
  assign StallM      = stall;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign regWriteW   = reg_write_w_q;
  assign MemToRegW   = mem_to_reg_w_q;
  assign ReadDataW   = read_data_w_q;
  assign ALUOutW     = alu_out_w_q;
  assign WriteRegW   = write_reg_w_q;
  assign align_err   = align_err_q;
  assign bus_err     = bus_err_q;

endmodule
